fsm_mode_arbiter: RTL
=====================

FSM_MODE_ARBITER -- requirements
Module: fsm_mode_arbiter

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset.
REQ-003 REQ0  input  1  requester 0 wants the mode FSM; held until GNT0.
REQ-004 MODE0  input  2  requester 0 mode {M0,M1}; sampled on grant.
REQ-005 REQ1  input  1  requester 1 request; same rules as REQ0.
REQ-006 MODE1  input  2  requester 1 mode {M0,M1}; sampled on grant.
REQ-007 DWELL  input  4  hold length in cycles; sampled on grant; 0 treated as 1.
REQ-008 T  input  1  FSM T output; ends the hold early.
REQ-009 GNT0, GNT1  output  1 each  one-cycle grant pulse to the winning requester.
REQ-010 M0, M1  output  1 each  mode drive to the FSM M0/M1 inputs.
REQ-011 FSM_RESET  output  1  reset drive to the FSM.
REQ-012 DONE  output  1  one-cycle pulse at end of each transaction.
REQ-013 BUSY  output  1  high in any state other than IDLE.

Function
REQ-014 States SHALL be IDLE, CLEAR, HOLD and RELEASE. All outputs SHALL be registered and Moore-decoded from state.
REQ-015 In IDLE, M0=M1=0, FSM_RESET=0 and DONE=0. IDLE with neither REQ high SHALL stay IDLE.
REQ-016 IDLE with at least one REQ high SHALL go to CLEAR on the next edge.
  - On that edge, the winner's MODE is latched.
  - On that edge, DWELL is latched into the down-counter.
REQ-017 Arbitration SHALL be round-robin.
  - Single requester: that requester wins.
  - Both requesting: the requester not granted last wins.
  - After reset, requester 0 wins a tie.
REQ-018 CLEAR SHALL last exactly 2 cycles with FSM_RESET=1 and M0=M1=0. GNTx SHALL be 1 only in the first CLEAR cycle.
REQ-019 HOLD SHALL drive {M0,M1} = latched mode and decrement the counter each cycle. Exit to RELEASE SHALL follow the cycle where the counter equals 1, giving DWELL hold cycles (1 if DWELL=0).
REQ-020 If T=1 in any HOLD cycle, the next state SHALL be RELEASE regardless of the counter value.
REQ-021 RELEASE SHALL last 1 cycle with DONE=1 and M0=M1=0, then go to IDLE.
REQ-022 Transaction length from the GNT cycle SHALL be 2 + hold + 1 cycles. At least one IDLE cycle SHALL separate transactions.
REQ-023 REQ changes outside IDLE SHALL be ignored. A REQ dropped before grant is a withdrawal and SHALL NOT be granted. MODE and DWELL changes after grant SHALL have no effect.
REQ-024 GNT0 and GNT1 SHALL never be high in the same cycle.

Reset
REQ-025 RESET=1 at an edge SHALL force IDLE from any state and clear the counter and latched mode. Round-robin priority SHALL return to requester 0.
REQ-026 During and after the reset edge, outputs SHALL be: GNT0=GNT1=0, M0=M1=0, DONE=0, BUSY=0, FSM_RESET=1.
REQ-027 FSM_RESET SHALL return to 0 on the first non-reset edge.
REQ-028 Reset mid-HOLD SHALL drop M0/M1 to 0 on the reset edge and SHALL NOT produce DONE.

Verification
REQ-029 Single request: REQ0=1, MODE0=01, DWELL=3, T=0.
  - Expect GNT0 pulse, FSM_RESET=1 for 2 cycles, {M0,M1}=01 for 3 cycles.
  - Then DONE for 1 cycle, then BUSY=0.
REQ-030 Tie and alternation: REQ0=REQ1=1 held high, MODE1=10.
  - Expect grant order GNT0, GNT1, GNT0, with one IDLE cycle between transactions.
  - Expect {M0,M1}=10 during the GNT1 hold.
REQ-031 Early end: DWELL=15, T=1 in the 2nd HOLD cycle.
  - Expect exactly 2 HOLD cycles, RELEASE next, then DONE=1.
REQ-032 Zero dwell: DWELL=0.
  - Expect exactly 1 HOLD cycle, total 4 BUSY cycles.
REQ-033 Reset mid-operation: RESET=1 in the 2nd HOLD cycle of a DWELL=5 transaction.
  - Expect M0=M1=0, BUSY=0, FSM_RESET=1 after the edge, and no DONE.
  - Then, with REQ0=REQ1=1, expect GNT0 first.
REQ-034 Withdrawal: REQ1 pulsed high for 1 cycle during a requester-0 HOLD, then low.
  - Expect no GNT1 and BUSY=0 after DONE.

Source files
------------

// File: rtl/fsm_mode_arbiter.sv
// Round-robin arbiter that grants one of two requesters exclusive use of a mode FSM:
// reset the FSM, drive the granted mode for a dwell period, then release it.
module fsm_mode_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [1:0] mode0,
    input  logic       req1,
    input  logic [1:0] mode1,
    input  logic [3:0] dwell,
    input  logic       t,
    output logic       gnt0,
    output logic       gnt1,
    output logic       m0,
    output logic       m1,
    output logic       fsm_reset,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t     state;
    logic       clear_second;   // set during the second CLEAR cycle
    logic [3:0] cnt;
    logic [1:0] mode_q;
    logic       last_gnt1;      // 1 when requester 1 won the previous arbitration
    logic       win1;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        win1 = 1'b0;
        if (req0 && req1)
            win1 = ~last_gnt1;
        else
            win1 = req1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            clear_second <= 1'b0;
            cnt          <= 4'd0;
            mode_q       <= 2'b00;
            last_gnt1    <= 1'b1;   // requester 0 wins the first tie
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            m0           <= 1'b0;
            m1           <= 1'b0;
            fsm_reset    <= 1'b1;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    m0        <= 1'b0;
                    m1        <= 1'b0;
                    fsm_reset <= 1'b0;
                    busy      <= 1'b0;
                    if (req0 || req1) begin
                        state        <= ST_CLEAR;
                        clear_second <= 1'b0;
                        busy         <= 1'b1;
                        fsm_reset    <= 1'b1;
                        gnt0         <= ~win1;
                        gnt1         <= win1;
                        last_gnt1    <= win1;
                        mode_q       <= win1 ? mode1 : mode0;
                        cnt          <= (dwell == 4'd0) ? 4'd1 : dwell;
                    end
                end

                ST_CLEAR: begin
                    if (!clear_second) begin
                        clear_second <= 1'b1;
                    end else begin
                        state     <= ST_HOLD;
                        fsm_reset <= 1'b0;
                        m0        <= mode_q[1];
                        m1        <= mode_q[0];
                    end
                end

                ST_HOLD: begin
                    cnt <= cnt - 4'd1;
                    // T ends the hold early regardless of the remaining count
                    if (t || cnt == 4'd1) begin
                        state <= ST_RELEASE;
                        m0    <= 1'b0;
                        m1    <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
